// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic pipeline boundary register with valid/ready, flush, stall and perf counters.
// Define PIPE_SKID_EN for the two-entry skid build with a registered upstream ready.
module pipe_stage_reg #(
  parameter int DATA_W       = 32,
  parameter bit CLR_ON_FLUSH = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_kill_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              any_valid;
  logic              up_xfer, dn_xfer;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  kill_cnt_q, kill_cnt_d;

  assign o_valid = main_v_q && !i_stall;
  assign o_data  = main_q;
  assign up_xfer = i_valid && o_ready;
  assign dn_xfer = o_valid && i_ready;

`ifdef PIPE_SKID_EN
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              rdy_q, rdy_d;

  // Upstream ready comes from a flop so i_ready never reaches o_ready.
  assign o_ready   = rdy_q && !i_stall;
  assign any_valid = main_v_q || skid_v_q;
  assign rdy_d     = !skid_v_d;

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (i_flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      if (CLR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else if (!i_stall) begin
      if (dn_xfer) begin
        if (skid_v_q) begin
          main_d   = skid_q;
          skid_v_d = 1'b0;
        end else if (up_xfer) begin
          main_d = i_data;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (up_xfer) begin
        if (!main_v_q) begin
          main_v_d = 1'b1;
          main_d   = i_data;
        end else begin
          skid_v_d = 1'b1;
          skid_d   = i_data;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      skid_v_q <= 1'b0;
      skid_q   <= '0;
      rdy_q    <= 1'b1;
    end else begin
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
      rdy_q    <= rdy_d;
    end
  end
`else
  assign o_ready   = !i_stall && (!main_v_q || i_ready);
  assign any_valid = main_v_q;

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    if (i_flush) begin
      main_v_d = 1'b0;
      if (CLR_ON_FLUSH) main_d = '0;
    end else if (!i_stall) begin
      if (up_xfer) begin
        main_v_d = 1'b1;
        main_d   = i_data;
      end else if (dn_xfer) begin
        main_v_d = 1'b0;
      end
    end
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    kill_cnt_d  = kill_cnt_q;
    if (i_stall && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
    if (i_flush && any_valid && kill_cnt_q != CNT_MAX) kill_cnt_d = kill_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_v_q    <= 1'b0;
      main_q      <= '0;
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_q      <= main_d;
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_kill_cnt  = kill_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg against a queue model.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, stall, flush;
  logic [31:0] in_data;

  logic        a_ready, a_valid, b_ready, b_valid;
  logic [31:0] a_data, b_data;
  logic [15:0] a_stall_cnt, a_kill_cnt;
  logic [1:0]  b_stall_cnt, b_kill_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(a_ready), .i_data(in_data),
    .o_valid(a_valid), .i_ready(out_ready), .o_data(a_data), .i_stall(stall), .i_flush(flush),
    .o_stall_cnt(a_stall_cnt), .o_kill_cnt(a_kill_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CLR_ON_FLUSH(1'b0), .CNT_W(2)) u_dut_sat (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(b_ready), .i_data(in_data),
    .o_valid(b_valid), .i_ready(out_ready), .o_data(b_data), .i_stall(stall), .i_flush(flush),
    .o_stall_cnt(b_stall_cnt), .o_kill_cnt(b_kill_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mq[$];
  logic [31:0] disp_clr, disp_hold;
  int          m_stall, m_kill;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int raw, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  function automatic logic exp_ready();
    if (stall) return 1'b0;
    if (CAP == 1) return (mq.size() == 0) || out_ready;
    return mq.size() < CAP;
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                       input logic rd, input logic st, input logic fl);
    logic er, ev, dn, up;
    logic [31:0] head;
    rst = r; in_valid = v; in_data = d; out_ready = rd; stall = st; flush = fl;
    @(negedge clk);
    er   = exp_ready();
    ev   = (mq.size() > 0) && !stall;
    head = (mq.size() > 0) ? mq[0] : 32'h0;
    check("ready", {63'h0, a_ready}, {63'h0, er});
    check("valid", {63'h0, a_valid}, {63'h0, ev});
    check("data_clr",  {32'h0, a_data}, {32'h0, (mq.size() > 0) ? head : disp_clr});
    check("data_hold", {32'h0, b_data}, {32'h0, (mq.size() > 0) ? head : disp_hold});
    check("ready_b", {63'h0, b_ready}, {63'h0, er});
    check("valid_b", {63'h0, b_valid}, {63'h0, ev});
    check("stall_cnt",   {48'h0, a_stall_cnt}, 64'(sat(m_stall, 16)));
    check("kill_cnt",    {48'h0, a_kill_cnt},  64'(sat(m_kill, 16)));
    check("stall_cnt_2", {62'h0, b_stall_cnt}, 64'(sat(m_stall, 2)));
    check("kill_cnt_2",  {62'h0, b_kill_cnt},  64'(sat(m_kill, 2)));
    @(posedge clk);
    if (r) begin
      mq.delete(); disp_clr = '0; disp_hold = '0; m_stall = 0; m_kill = 0;
    end else begin
      if (st) m_stall++;
      if (fl) begin
        if (mq.size() > 0) m_kill++;
        mq.delete();
        disp_clr = '0;
      end else if (!st) begin
        dn = (mq.size() > 0) && rd;
        up = v && er;
        if (dn) void'(mq.pop_front());
        if (up) mq.push_back(d);
      end
      if (mq.size() > 0) begin
        disp_clr  = mq[0];
        disp_hold = mq[0];
      end
    end
    #1;
  endtask

  int sat_seq[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    disp_clr = '0; disp_hold = '0; m_stall = 0; m_kill = 0;
    @(posedge clk); #1;

    // reset with a live upstream beat
    cycle(1, 1, 32'hDEADBEEF, 1, 0, 0);
    cycle(1, 1, 32'hDEADBEEF, 1, 0, 0);
    check("rst_valid", {63'h0, a_valid}, 64'h0);
    check("rst_data", {32'h0, a_data}, 64'h0);
    check("rst_cnt", {32'h0, a_stall_cnt, a_kill_cnt}, 64'h0);

    // back-to-back stream
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 1, 32'(i), 1, 0, 0);
      check("stream_data", {32'h0, a_data}, 64'(i));
      check("stream_valid", {63'h0, a_valid}, 64'h1);
    end
    cycle(0, 0, 0, 1, 0, 0);

    // stall holds a beat
    cycle(0, 1, 32'hA5, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, 0);
    check("stall_cnt3", {48'h0, a_stall_cnt}, 64'd3);
    check("stall_hold", {32'h0, a_data}, 64'hA5);
    cycle(0, 0, 0, 1, 0, 0);
    check("after_stall_empty", {63'h0, a_valid}, 64'h0);

    // flush with incoming beat, then flush while empty
    cycle(0, 1, 32'h55, 0, 0, 0);
    cycle(0, 1, 32'h77, 0, 0, 1);
    check("flush_valid", {63'h0, a_valid}, 64'h0);
    check("flush_data_clr", {32'h0, a_data}, 64'h0);
    check("flush_data_hold", {32'h0, b_data}, 64'h55);
    check("flush_kill", {48'h0, a_kill_cnt}, 64'd1);
    cycle(0, 0, 0, 0, 0, 1);
    check("flush_empty_kill", {48'h0, a_kill_cnt}, 64'd1);

`ifdef PIPE_SKID_EN
    cycle(0, 1, 32'h10, 0, 0, 0);
    cycle(0, 1, 32'h11, 0, 0, 0);
    check("skid_full_ready", {63'h0, a_ready}, 64'h0);
    cycle(0, 1, 32'h12, 0, 0, 0);
    cycle(0, 1, 32'h12, 1, 0, 0);
    check("skid_second", {32'h0, a_data}, 64'h11);
    cycle(0, 1, 32'h12, 1, 0, 0);
    check("skid_third", {32'h0, a_data}, 64'h12);
    cycle(0, 0, 0, 1, 0, 0);
`endif

    // 2-bit counter saturation
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 1, 0);
      check("sat_seq", {62'h0, b_stall_cnt}, 64'(sat_seq[i]));
    end

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0, ($urandom % 3) != 0, $urandom,
            ($urandom % 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline boundary register. It is the successor to the fixed per-stage registers between decode/execute/memory/writeback.
- Carries an opaque DATA_W-bit payload with valid/ready handshake, plus flush (kill) and stall (freeze) controls from the hazard unit.
- Saturating stall/kill counters for performance debug.
- One instance per stage boundary. Control and data bundles are packed into the payload by the instantiating stage.

Parameters:
- DATA_W, 32: payload width in bits (1..1024).
- CLR_ON_FLUSH, 1: 1 = payload registers zeroed on flush; 0 = only valid bits cleared, payload held.
- CNT_W, 16: width of each performance counter (2..32).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  stage can accept a beat this cycle.
- i_data  in  DATA_W  upstream payload.
- o_valid  out  1  downstream beat valid.
- i_ready  in  1  downstream accepts beat.
- o_data  out  DATA_W  downstream payload.
- i_stall  in  1  freeze: no load, no drain.
- i_flush  in  1  kill all held beats.
- o_stall_cnt  out  CNT_W  cycles with i_stall high (saturating).
- o_kill_cnt  out  CNT_W  flush cycles that discarded at least one valid beat (saturating).

Behaviour:
- Priority each cycle: i_rst > i_flush > i_stall > handshake.
- Reset values:
  - o_valid = 0; o_data = 0; o_stall_cnt = 0; o_kill_cnt = 0.
  - Skid entry empty; in skid build, ready register = 1.
  - Reset mid-transfer discards all beats with no output pulse.
- Transfer rules:
  - Upstream transfer = i_valid && o_ready.
  - Downstream transfer = o_valid && i_ready.
  - o_valid and o_data depend only on registered state and i_stall; no combinational path from i_data.
- Base build (macro undefined):
  - Single entry, valid_q.
  - o_ready = !i_stall && (!valid_q || i_ready).
  - o_valid = valid_q && !i_stall.
  - On upstream transfer: data_q <= i_data, valid_q <= 1, next cycle.
  - Else on downstream transfer: valid_q <= 0.
  - Simultaneous in/out transfers in the same cycle sustain 1 beat/cycle.
  - Latency 1 cycle.
- Stall (i_stall = 1, no flush):
  - All state holds.
  - o_ready = 0 and o_valid = 0, so no handshake occurs at either side.
  - Payload is visible on o_data but not valid.
- Flush (i_flush = 1):
  - All valid bits <= 0; i_valid ignored that cycle.
  - o_ready may read 1, but no beat is captured.
  - Payload <= 0 if CLR_ON_FLUSH = 1, else held.
  - Flush during stall still flushes.
  - Flush with no valid beat held does not increment o_kill_cnt.
- Counters:
  - o_stall_cnt += 1 each cycle i_stall = 1, including flush cycles.
  - o_kill_cnt += 1 on a flush cycle where any valid entry is held.
  - Both saturate at 2^CNT_W - 1 and never wrap.
  - Cleared only by reset.
- Ordering: beats leave in arrival order. No duplication and no loss except by flush/reset.

Optional Feature:
- Macro PIPE_SKID_EN.
- Defined:
  - Two entries: main (drives o_valid/o_data) plus a skid entry.
  - Registered ready r_q = !skid_valid; o_ready = r_q && !i_stall. The only combinational term is i_stall, with no path from i_ready.
  - Beat accepted while main is full and not draining goes to skid.
  - On main draining: skid -> main when skid is valid, else the incoming beat -> main.
  - Full throughput of 1 beat/cycle; latency 1 cycle.
  - Flush clears both entries; counts as one kill if either was valid.
- Undefined: base build as above; skid logic absent.

Test Plan:
- Reset held 2 cycles with i_valid = 1, i_data = 0xDEADBEEF -> o_valid = 0, o_data = 0, counters 0, and no capture after reset deasserts until the next edge.
- Stream 0x1, 0x2, 0x3 on consecutive cycles with i_ready = 1 -> o_data = 0x1, 0x2, 0x3 on cycles 1, 2, 3 with o_valid = 1 each cycle.
- Hold 0xA5, then assert i_stall for 3 cycles with i_ready = 1 -> o_valid = 0 and o_ready = 0 during stall; 0xA5 emitted once after stall drops; o_stall_cnt = 3.
- Hold 0x55 and assert i_flush with i_valid = 1, i_data = 0x77 -> next cycle o_valid = 0, o_data = 0 (CLR_ON_FLUSH = 1), 0x77 dropped, o_kill_cnt = 1. A second flush while empty leaves o_kill_cnt = 1.
- With PIPE_SKID_EN, hold i_ready = 0, stream 0x10, 0x11, 0x12 -> 0x10 and 0x11 accepted, o_ready = 0 after the second beat, 0x12 held upstream. Raising i_ready gives output 0x10, 0x11, 0x12 in order.
- CNT_W = 2, i_stall high 6 cycles -> o_stall_cnt sequence 1, 2, 3, 3, 3, 3 (saturates).
